multi_phase_traffic_controller: RTL and testbench

Parametrised successor to the two-road main/side traffic light controller. It generalises to N_PHASES signal phases with sensor-actuated, round-robin phase service. Green time is configurable with a minimum and maximum and is extended while the phase's own sensor is active. Each green starts with a protected left-turn window, and every phase change passes through yellow and all-red clearance. It sits at intersection-controller level and drives lamp outputs directly.

---
 rtl/multi_phase_traffic_controller.sv | 151 +++++++++++++++
 tb/tb_multi_phase_traffic_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multi_phase_traffic_controller.sv
// Sensor-actuated round-robin traffic controller for N_PHASES signal phases.
// Latency: lamp outputs are registered and follow a state change on the same clk edge.
// Backpressure: none; sensors are sampled every cycle and latched as demand.
//
// Ports:
//   clk, rst_n    - rising-edge clock, asynchronous active-low reset
//   sensor        - per-phase vehicle detect (level or single-cycle pulse)
//   lights        - per phase p, bits [3p+2:3p]: 100 red, 010 yellow, 001 green
//   turn_left     - protected left-turn arrow, one bit per phase
//   active_phase  - phase owning green/yellow (held through all-red)
//   state         - 00 ALLRED, 01 GREEN, 10 YELLOW
//   counter       - cycles elapsed in the current state, 0 on entry
module multi_phase_traffic_controller #(
  parameter int N_PHASES  = 4,
  parameter int CNT_W     = 6,
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int TURN_T    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_PHASES-1:0]           sensor,
  output logic [3*N_PHASES-1:0]         lights,
  output logic [N_PHASES-1:0]           turn_left,
  output logic [$clog2(N_PHASES)-1:0]   active_phase,
  output logic [1:0]                    state,
  output logic [CNT_W-1:0]              counter
);

  localparam int PW = $clog2(N_PHASES);

  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W:0]   TURN_C  = (CNT_W+1)'(TURN_T);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         active_q, active_d;
  logic [CNT_W-1:0]      counter_q, counter_d;
  logic [N_PHASES-1:0]   demand_q, demand_d;
  logic [3*N_PHASES-1:0] lights_q, lights_d;
  logic [N_PHASES-1:0]   turn_q, turn_d;

  logic [N_PHASES-1:0]   act_mask;
  logic [PW-1:0]         next_ph;
  logic                  found;
  logic                  other_demand;

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    counter_d = counter_q;
    act_mask  = N_PHASES'(1) << active_q;
    other_demand = |(demand_q & ~act_mask);

    // Round-robin search starting after the active phase; the active phase
    // itself is considered last. With no demand, advance by one.
    next_ph = PW'((int'(active_q) + 1) % N_PHASES);
    found   = 1'b0;
    for (int k = 1; k <= N_PHASES; k++) begin
      if (!found && demand_q[(int'(active_q) + k) % N_PHASES]) begin
        next_ph = PW'((int'(active_q) + k) % N_PHASES);
        found   = 1'b1;
      end
    end

    // The green phase does not register demand for itself.
    if (state_q == ST_GREEN) demand_d = demand_q | (sensor & ~act_mask);
    else                     demand_d = demand_q | sensor;

    case (state_q)
      ST_ALLRED: begin
        if (counter_q == AR_M1) begin
          state_d           = ST_GREEN;
          active_d          = next_ph;
          counter_d         = '0;
          demand_d[next_ph] = 1'b0;  // served: a same-edge sensor hit is dropped
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      ST_GREEN: begin
        if (counter_q >= GMIN_M1 && other_demand &&
            (!sensor[active_q] || counter_q >= GMAX_M1)) begin
          state_d   = ST_YELLOW;
          counter_d = '0;
        end else if (counter_q < GMAX_M1) begin
          counter_d = counter_q + CNT_W'(1);
        end
        // Saturation at GREEN_MAX-1 lets late demand end a rest-in-green
        // on the very next edge even while the own sensor is active.
      end
      ST_YELLOW: begin
        if (counter_q == YEL_M1) begin
          state_d   = ST_ALLRED;
          counter_d = '0;
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_ALLRED;
        counter_d = '0;
      end
    endcase

    // Lamp decode from next state so the lamp registers line up with state_q.
    lights_d = {N_PHASES{3'b100}};
    turn_d   = '0;
    if (state_d == ST_GREEN) begin
      lights_d[3*active_d +: 3] = 3'b001;
      if ({1'b0, counter_d} < TURN_C) turn_d[active_d] = 1'b1;
    end else if (state_d == ST_YELLOW) begin
      lights_d[3*active_d +: 3] = 3'b010;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ALLRED;
      active_q  <= PW'(N_PHASES - 1);
      counter_q <= '0;
      demand_q  <= '0;
      lights_q  <= {N_PHASES{3'b100}};
      turn_q    <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      counter_q <= counter_d;
      demand_q  <= demand_d;
      lights_q  <= lights_d;
      turn_q    <= turn_d;
    end
  end

  assign state        = state_q;
  assign active_phase = active_q;
  assign counter      = counter_q;
  assign lights       = lights_q;
  assign turn_left    = turn_q;

endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
module tb_multi_phase_traffic_controller;

  localparam logic [1:0] AR = 2'b00;
  localparam logic [1:0] GR = 2'b01;
  localparam logic [1:0] YE = 2'b10;

  // Lamp images for 4 phases, phase 0 in the low bits.
  localparam logic [11:0] RED = 12'h924;
  localparam logic [11:0] G0  = 12'h921;
  localparam logic [11:0] Y0  = 12'h922;
  localparam logic [11:0] G1  = 12'h90C;
  localparam logic [11:0] Y1  = 12'h914;
  localparam logic [11:0] G2  = 12'h864;
  localparam logic [11:0] Y2  = 12'h8A4;
  localparam logic [11:0] G3  = 12'h324;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sensor;
  logic [11:0] lights;
  logic [3:0]  turn_left;
  logic [1:0]  active_phase;
  logic [1:0]  state;
  logic [5:0]  counter;

  int n_cmp = 0;
  int n_err = 0;

  multi_phase_traffic_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sensor       (sensor),
    .lights       (lights),
    .turn_left    (turn_left),
    .active_phase (active_phase),
    .state        (state),
    .counter      (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [1:0] st, input logic [1:0] ph,
                         input logic [5:0] cnt, input logic [11:0] lt, input logic [3:0] tl);
    chk({nm, ".state"}, 32'(state), 32'(st));
    chk({nm, ".phase"}, 32'(active_phase), 32'(ph));
    chk({nm, ".counter"}, 32'(counter), 32'(cnt));
    chk({nm, ".lights"}, 32'(lights), 32'(lt));
    chk({nm, ".turn"}, 32'(turn_left), 32'(tl));
  endtask

  // Drive sensor, let n rising edges pass, then compare at the falling edge.
  task automatic run_chk(input string nm, input logic [3:0] sen, input int n,
                         input logic [1:0] st, input logic [1:0] ph, input logic [5:0] cnt,
                         input logic [11:0] lt, input logic [3:0] tl);
    sensor = sen;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk_all(nm, st, ph, cnt, lt, tl);
  endtask

  // Assert reset between edges, check it took effect without a clock,
  // release on a falling edge.
  task automatic do_reset(input string nm);
    @(negedge clk);
    sensor = 4'b0000;
    #2 rst_n = 1'b0;
    #1 chk_all(nm, AR, 2'd3, 6'd0, RED, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Safety invariants, checked every cycle outside reset.
  always @(negedge clk) begin
    int nr;
    if (rst_n === 1'b1) begin
      nr = 0;
      for (int p = 0; p < 4; p++) begin
        if (lights[3*p +: 3] != 3'b100) nr++;
        if (turn_left[p]) chk("turn_implies_green", 32'(lights[3*p +: 3]), 32'd1);
      end
      chk("one_nonred", 32'(nr <= 1), 32'd1);
      chk("one_turn", 32'($countones(turn_left) <= 1), 32'd1);
    end
  end

  typedef struct {
    bit          rst;
    logic [3:0]  sen;
    int          n;
    logic [1:0]  st;
    logic [1:0]  ph;
    logic [5:0]  cnt;
    logic [11:0] lt;
    logic [3:0]  tl;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst_n  = 1'b1;
    sensor = 4'b0000;

    // Idle start, rest in green, late demand after saturation.
    tbl.push_back('{1, 4'b0000,  1, AR, 2'd3,  6'd1, RED, 4'b0000});
    tbl.push_back('{0, 4'b0000,  1, GR, 2'd0,  6'd0, G0,  4'b0001});
    tbl.push_back('{0, 4'b0000,  2, GR, 2'd0,  6'd2, G0,  4'b0001});
    tbl.push_back('{0, 4'b0000,  1, GR, 2'd0,  6'd3, G0,  4'b0000});
    tbl.push_back('{0, 4'b0000, 30, GR, 2'd0, 6'd19, G0,  4'b0000});
    tbl.push_back('{0, 4'b0100,  1, GR, 2'd0, 6'd19, G0,  4'b0000});
    tbl.push_back('{0, 4'b0000,  1, YE, 2'd0,  6'd0, Y0,  4'b0000});
    tbl.push_back('{0, 4'b0000,  2, YE, 2'd0,  6'd2, Y0,  4'b0000});
    tbl.push_back('{0, 4'b0000,  1, AR, 2'd0,  6'd0, RED, 4'b0000});
    tbl.push_back('{0, 4'b0000,  2, GR, 2'd2,  6'd0, G2,  4'b0100});
    // Own sensor extends green to GREEN_MAX, then phase 1 rests.
    tbl.push_back('{1, 4'b0011,  2, GR, 2'd0,  6'd0, G0,  4'b0001});
    tbl.push_back('{0, 4'b0011, 19, GR, 2'd0, 6'd19, G0,  4'b0000});
    tbl.push_back('{0, 4'b0011,  1, YE, 2'd0,  6'd0, Y0,  4'b0000});
    tbl.push_back('{0, 4'b0000,  5, GR, 2'd1,  6'd0, G1,  4'b0010});
    tbl.push_back('{0, 4'b0000, 25, GR, 2'd1, 6'd19, G1,  4'b0000});
    // Two latched demands served in round-robin order 1 then 3.
    tbl.push_back('{1, 4'b0000,  2, GR, 2'd0,  6'd0, G0,  4'b0001});
    tbl.push_back('{0, 4'b1010,  1, GR, 2'd0,  6'd1, G0,  4'b0001});
    tbl.push_back('{0, 4'b0000,  6, GR, 2'd0,  6'd7, G0,  4'b0000});
    tbl.push_back('{0, 4'b0000,  1, YE, 2'd0,  6'd0, Y0,  4'b0000});
    tbl.push_back('{0, 4'b0000,  5, GR, 2'd1,  6'd0, G1,  4'b0010});
    tbl.push_back('{0, 4'b0000,  7, GR, 2'd1,  6'd7, G1,  4'b0000});
    tbl.push_back('{0, 4'b0000,  1, YE, 2'd1,  6'd0, Y1,  4'b0000});
    tbl.push_back('{0, 4'b0000,  5, GR, 2'd3,  6'd0, G3,  4'b1000});
    tbl.push_back('{0, 4'b0000, 25, GR, 2'd3, 6'd19, G3,  4'b0000});
    // All sensors held: full cycle 0,1,2,3,0 at 25 cycles per phase.
    tbl.push_back('{1, 4'b1111,  2, GR, 2'd0,  6'd0, G0,  4'b0001});
    tbl.push_back('{0, 4'b1111, 19, GR, 2'd0, 6'd19, G0,  4'b0000});
    tbl.push_back('{0, 4'b1111,  1, YE, 2'd0,  6'd0, Y0,  4'b0000});
    tbl.push_back('{0, 4'b1111,  5, GR, 2'd1,  6'd0, G1,  4'b0010});
    tbl.push_back('{0, 4'b1111, 20, YE, 2'd1,  6'd0, Y1,  4'b0000});
    tbl.push_back('{0, 4'b1111,  5, GR, 2'd2,  6'd0, G2,  4'b0100});
    tbl.push_back('{0, 4'b1111, 25, GR, 2'd3,  6'd0, G3,  4'b1000});
    tbl.push_back('{0, 4'b1111, 25, GR, 2'd0,  6'd0, G0,  4'b0001});

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset($sformatf("rst%0d", i));
      run_chk($sformatf("row%0d", i), tbl[i].sen, tbl[i].n, tbl[i].st, tbl[i].ph,
              tbl[i].cnt, tbl[i].lt, tbl[i].tl);
    end

    // Minimum green with a one-cycle pulse, demand clearing, reset mid-yellow.
    do_reset("A_init");
    run_chk("A0",  4'b0000,  2, GR, 2'd0,  6'd0, G0,  4'b0001);
    run_chk("A1",  4'b0000,  1, GR, 2'd0,  6'd1, G0,  4'b0001);
    run_chk("A2",  4'b0100,  1, GR, 2'd0,  6'd2, G0,  4'b0001);
    run_chk("A3",  4'b0000,  5, GR, 2'd0,  6'd7, G0,  4'b0000);
    run_chk("A4",  4'b0000,  1, YE, 2'd0,  6'd0, Y0,  4'b0000);
    run_chk("A5",  4'b0000,  3, AR, 2'd0,  6'd0, RED, 4'b0000);
    run_chk("A6",  4'b0000,  2, GR, 2'd2,  6'd0, G2,  4'b0100);
    run_chk("A7",  4'b0000, 25, GR, 2'd2, 6'd19, G2,  4'b0000);
    run_chk("A8",  4'b1000,  1, GR, 2'd2, 6'd19, G2,  4'b0000);
    run_chk("A9",  4'b0000,  2, YE, 2'd2,  6'd1, Y2,  4'b0000);
    run_chk("A10", 4'b0010,  1, YE, 2'd2,  6'd2, Y2,  4'b0000);
    sensor = 4'b0000;
    #2 rst_n = 1'b0;
    #1 chk_all("A_midyel_rst", AR, 2'd3, 6'd0, RED, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    run_chk("A11", 4'b0000,  2, GR, 2'd0,  6'd0, G0,  4'b0001);
    run_chk("A12", 4'b0000, 25, GR, 2'd0, 6'd19, G0,  4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
